// File: rtl/seqdet_pkg.sv
// Shared definitions for the programmable serial sequence detector.
// Holds the reset-default configuration, the overlap-mode type, the
// length-field width helper, the length clamp and the length-masked
// pattern compare.
package seqdet_pkg;

  localparam logic [7:0]  DEFAULT_PATTERN = 8'b0000_1001;
  localparam int unsigned DEFAULT_LEN     = 4;
  localparam logic        DEFAULT_OVERLAP = 1'b1;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } overlap_e;

  // Width of a field able to hold 0..max_len inclusive.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $unsigned($clog2(max_len)) + 32'd1;
  endfunction

  // Lengths below 1 collapse to single-bit detect; lengths above the
  // history depth are cut to the depth.
  function automatic int unsigned clamp_len(input int unsigned raw,
                                            input int unsigned max_len);
    if (raw < 32'd1)  return 32'd1;
    if (raw > max_len) return max_len;
    return raw;
  endfunction

  // Compares only the low len bits. Operands are carried as 32 bits, so
  // detectors using this helper are limited to 32-bit patterns.
  function automatic logic masked_equal(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input int unsigned len);
    logic [31:0] mask;
    mask = (len >= 32'd32) ? '1 : ((32'd1 << len) - 32'd1);
    return ((a ^ b) & mask) == '0;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with sticky saturation flag.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   inc   : count one event
//   clr   : synchronous clear of count and sat (wins over inc)
//   count : current count, holds at all-ones
//   sat   : set once count reaches all-ones, held until clr/reset
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;
  logic             sat_q;

  always_comb begin
    count_inc = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_inc;
      if (count_inc == '1) sat_q <= 1'b1;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/param_sequence_detector.sv
// Serial-bit sequence detector with runtime-programmable pattern.
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset; restores default config
//   in          : serial data bit
//   in_valid    : qualifies in
//   cfg_load    : strobe latching cfg_pattern/cfg_len/cfg_overlap, clears
//                 partial-match history (bit on in is discarded)
//   cfg_pattern : pattern, bit [len-1] received first, bit 0 last
//   cfg_len     : pattern length, clamped to 1..MAX_LEN
//   cfg_overlap : 1 = overlapping matches, 0 = non-overlapping
//   count_clr   : synchronous clear of match_count/count_sat
//   out         : one-cycle registered match pulse
//   match_count : saturating number of matches
//   count_sat   : sticky saturation flag
// MAX_LEN must lie in 2..32.
module param_sequence_detector
  import seqdet_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEFAULT_PATTERN),
  parameter int unsigned        DEF_LEN     = DEFAULT_LEN,
  parameter logic               DEF_OVERLAP = DEFAULT_OVERLAP
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in,
  input  logic                        in_valid,
  input  logic                        cfg_load,
  input  logic [MAX_LEN-1:0]          cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
  input  logic                        cfg_overlap,
  input  logic                        count_clr,
  output logic                        out,
  output logic [CNT_W-1:0]            match_count,
  output logic                        count_sat
);

  localparam int unsigned      LEN_W   = len_w(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(clamp_len(DEF_LEN, MAX_LEN));

  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   fill_n;
  overlap_e           overlap_q;
  logic               accept;
  logic               hit;
  logic               out_q;

  // hit is evaluated on the would-be next history, so the pulse appears
  // registered one cycle after the final pattern bit is sampled.
  always_comb begin
    accept   = in_valid & ~cfg_load;
    hist_n   = {hist_q[MAX_LEN-2:0], in};
    fill_inc = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
    hit      = (fill_inc == len_q) &&
               masked_equal(32'(hist_n), 32'(pattern_q), 32'(len_q));
    // Non-overlapping mode restarts the fill so the next match needs
    // a full set of fresh bits.
    fill_n   = (hit && (overlap_q == OVL_OFF)) ? '0 : fill_inc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
      pattern_q <= DEF_PATTERN;
      len_q     <= RST_LEN;
      overlap_q <= overlap_e'(DEF_OVERLAP);
    end else if (cfg_load) begin
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
      pattern_q <= cfg_pattern;
      len_q     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
      overlap_q <= overlap_e'(cfg_overlap);
    end else if (in_valid) begin
      hist_q    <= hist_n;
      fill_q    <= fill_n;
      out_q     <= hit;
    end else begin
      out_q     <= 1'b0;
    end
  end

  assign out = out_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (accept & hit),
    .clr   (count_clr),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule

// File: tb/tb_param_sequence_detector.sv
module tb_param_sequence_detector;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned CNT_MAX = 7;

  logic       clock = 1'b0;
  logic       reset;
  logic       in;
  logic       in_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       count_clr;
  logic       out;
  logic [2:0] match_count;
  logic       count_sat;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;
  int pulses   = 0;

  // Reference model: received bits kept as a plain list since the last
  // history loss; a match is "the newest len bits spell the pattern".
  logic [7:0]  m_pattern;
  int unsigned m_len;
  logic        m_ovl;
  logic        m_bits[$];
  int unsigned m_count;
  logic        m_sat;
  logic        m_out;

  logic        r_ld, r_v, r_b, r_o, r_c;
  logic [7:0]  r_p;
  logic [3:0]  r_l;

  param_sequence_detector #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in          (in),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .out         (out),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    assert (actual === expected) else begin
      failures++;
      $error("FAIL %s step=%0d actual=%0h required=%0h",
             tag, step_no, actual, expected);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_out"},   32'(out),         32'(m_out));
    check({tag, "_count"}, 32'(match_count), m_count);
    check({tag, "_sat"},   32'(count_sat),   32'(m_sat));
  endtask

  task automatic model_reset();
    m_pattern = 8'b0000_1001;
    m_len     = 4;
    m_ovl     = 1'b1;
    m_bits.delete();
    m_count   = 0;
    m_sat     = 1'b0;
    m_out     = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic v, input logic ld,
                            input logic [7:0] p, input logic [3:0] l,
                            input logic o, input logic c);
    logic match;
    match = 1'b0;
    if (ld) begin
      m_pattern = p;
      m_len     = (l < 1) ? 1 : ((l > MAX_LEN) ? MAX_LEN : 32'(l));
      m_ovl     = o;
      m_bits.delete();
      m_out     = 1'b0;
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      if (m_bits.size() >= int'(m_len)) begin
        match = 1'b1;
        for (int k = 0; k < int'(m_len); k++)
          if (m_bits[m_bits.size() - 1 - k] !== m_pattern[k]) match = 1'b0;
      end
      m_out = match;
      if (match && !m_ovl) m_bits.delete();
    end else begin
      m_out = 1'b0;
    end
    if (c) begin
      m_count = 0;
      m_sat   = 1'b0;
    end else if (match) begin
      if (m_count < CNT_MAX) m_count++;
      if (m_count == CNT_MAX) m_sat = 1'b1;
    end
  endtask

  task automatic step(input logic b, input logic v, input logic ld,
                      input logic [7:0] p, input logic [3:0] l,
                      input logic o, input logic c);
    in = b; in_valid = v; cfg_load = ld;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; count_clr = c;
    model_step(b, v, ld, p, l, o, c);
    @(posedge clock);
    #1;
    step_no++;
    check_all("step");
    if (out === 1'b1) pulses++;
  endtask

  task automatic bit_in(input logic b);
    step(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic b, input logic c);
    step(b, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, c);
  endtask

  initial begin
    reset = 1'b0; in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    check_all("reset_release");

    // Default config, overlapping: 1001001 matches twice.
    pulses = 0;
    bit_in(1); bit_in(0); bit_in(0); bit_in(1); bit_in(0); bit_in(0); bit_in(1);
    check("t1_pulses", 32'(pulses), 32'd2);
    check("t1_count", 32'(match_count), 32'd2);

    // Non-overlapping: same stream matches once.
    idle(1'b0, 1'b1);
    step(0, 0, 1, 8'b0000_1001, 4'd4, 1'b0, 1'b0);
    pulses = 0;
    bit_in(1); bit_in(0); bit_in(0); bit_in(1); bit_in(0); bit_in(0); bit_in(1);
    check("t2_pulses", 32'(pulses), 32'd1);
    check("t2_count", 32'(match_count), 32'd1);

    // Default config with invalid gaps carrying junk data.
    step(0, 0, 1, 8'b0000_1001, 4'd4, 1'b1, 1'b0);
    pulses = 0;
    bit_in(1); idle(0, 0); idle(1, 0); idle(1, 0);
    bit_in(0); idle(1, 0); idle(0, 0); idle(1, 0);
    bit_in(0); idle(1, 0); idle(1, 0); idle(0, 0);
    bit_in(1); idle(1, 0); idle(0, 0); idle(1, 0);
    check("t3_pulses", 32'(pulses), 32'd1);
    check("t3_count", 32'(match_count), 32'd2);

    // Mid-stream load with a simultaneous valid bit that must be dropped.
    pulses = 0;
    step(1, 1, 1, 8'b0000_0110, 4'd3, 1'b1, 1'b0);
    bit_in(1); bit_in(0);
    check("t4_no_early", 32'(pulses), 32'd0);
    bit_in(1); bit_in(1); bit_in(0);
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_count", 32'(match_count), 32'd3);

    // Single-bit pattern: saturate the 3-bit counter, then clear on a match.
    step(0, 0, 1, 8'h01, 4'd1, 1'b1, 1'b1);
    pulses = 0;
    for (int i = 0; i < 9; i++) bit_in(1);
    check("t5_pulses", 32'(pulses), 32'd9);
    check("t5_count", 32'(match_count), 32'd7);
    check("t5_sat", 32'(count_sat), 32'd1);
    step(1, 1, 0, 8'h00, 4'd0, 1'b0, 1'b1);
    check("t5_clr_out", 32'(out), 32'd1);
    check("t5_clr_count", 32'(match_count), 32'd0);
    check("t5_clr_sat", 32'(count_sat), 32'd0);

    // Length clamping: 0 behaves as 1, 15 behaves as 8.
    step(0, 0, 1, 8'h00, 4'd0, 1'b0, 1'b0);
    pulses = 0;
    bit_in(0); bit_in(1); bit_in(0);
    check("t6_len0", 32'(pulses), 32'd2);
    step(0, 0, 1, 8'b1010_0110, 4'd15, 1'b1, 1'b0);
    pulses = 0;
    bit_in(1); bit_in(0); bit_in(1); bit_in(0);
    bit_in(0); bit_in(1); bit_in(1); bit_in(0);
    check("t6_len15", 32'(pulses), 32'd1);

    // Asynchronous reset in the middle of a partial match.
    step(0, 0, 1, 8'b0000_1001, 4'd4, 1'b1, 1'b1);
    bit_in(1); bit_in(0); bit_in(0);
    #3 reset = 1'b0;
    model_reset();
    #1;
    check_all("t7_reset");
    #2 reset = 1'b1;
    pulses = 0;
    bit_in(1);
    check("t7_pulses", 32'(pulses), 32'd0);
    check("t7_count", 32'(match_count), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r_ld = ($urandom_range(0, 99) < 4);
      r_v  = ($urandom_range(0, 99) < 75);
      r_b  = 1'($urandom_range(0, 1));
      r_p  = 8'($urandom());
      r_l  = 4'($urandom_range(0, 15));
      r_o  = 1'($urandom_range(0, 1));
      r_c  = ($urandom_range(0, 99) < 6);
      step(r_b, r_v, r_ld, r_p, r_l, r_o, r_c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_sequence_detector.md
Name: param_sequence_detector

Overview:
- Serial-bit sequence detector with a runtime-programmable pattern of 1..MAX_LEN bits.
- Selectable overlapping or non-overlapping detection, and qualified input (in_valid).
- Raises a one-cycle match pulse and keeps a saturating match counter.
- Successor to the fixed-pattern detector; sits on a serial input stream feeding control/status logic.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- CNT_W, 8: match counter width.
- DEF_PATTERN, 8'b0000_1001: pattern loaded at reset (LSB-aligned).
- DEF_LEN, 4: pattern length loaded at reset.
- DEF_OVERLAP, 1: overlap mode at reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears state immediately).
- in  in  1  serial data bit.
- in_valid  in  1  bit qualifier; `in` is sampled only when 1.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first-received bit, bit 0 the last.
- cfg_len  in  LEN_W  pattern length; LEN_W = clog2(MAX_LEN)+1.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- count_clr  in  1  synchronous clear of match_count and count_sat.
- out  out  1  registered match pulse, high for exactly one cycle per match.
- match_count  out  CNT_W  number of matches, saturating.
- count_sat  out  1  sticky flag: counter reached all-ones.

Behaviour:
- Reset (reset=0, async):
  - hist=0, fill=0, out=0, match_count=0, count_sat=0.
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
- Internal state:
  - hist[MAX_LEN-1:0]: shift register of received bits, newest in bit 0.
  - fill: number of valid history bits, 0..len.
- Accepted bit (in_valid=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], in}.
  - fill_n = min(fill+1, len).
- Match condition: fill_n == len and hist_n[len-1:0] == pattern[len-1:0], comparing only the low len bits.
- Output timing:
  - out is registered: high in the cycle after the edge that sampled the final pattern bit.
  - Latency is 1 clock; out is 0 in every cycle with no match.
- Overlap=1: fill stays at len after a match; shared suffix bits may begin the next match.
- Overlap=0: fill is forced to 0 on a match; the next match needs len freshly accepted bits.
- in_valid=0: hist, fill and out-generation are frozen; out=0 next cycle.
- cfg_load=1:
  - Latches the new config and clears hist and fill; out=0 next cycle.
  - match_count is retained.
  - cfg_load has priority over a simultaneous in_valid; that bit is discarded.
- Length clamping:
  - cfg_len=0 or 1 is stored as 1 (single-bit detect).
  - cfg_len>MAX_LEN is stored as MAX_LEN.
- match_count:
  - Increments by 1 per match.
  - At all-ones it holds, and count_sat is set.
  - count_sat stays set until count_clr or reset.
- count_clr:
  - Clears match_count and count_sat.
  - If asserted in the same cycle as a match, clear wins: count=0, but out still pulses.
- Reset mid-stream: all partial-match history is lost, and config reverts to the defaults.

Decomposition:
- Shared package seqdet_pkg holds:
  - the LEN_W computation function;
  - default constants DEF_PATTERN, DEF_LEN, DEF_OVERLAP;
  - the len-clamp function;
  - the length-masked compare function.
- Sub-module: sat_counter (CNT_W param; inc, clr; outputs count and sat), instantiated once for match_count/count_sat.

Test Plan:
- Default config, overlap=1, in_valid=1, bits 1,0,0,1,0,0,1 -> out pulses after the 4th and 7th bits; match_count=2.
- cfg_load pattern=4'b1001, len=4, overlap=0, same stream -> one pulse after the 4th bit only; match_count=1.
- Default config, bits 1,0,0,1 with in_valid=0 gaps of 3 cycles between bits -> exactly one pulse, one cycle after the final valid bit; no pulses during gaps.
- Mid-stream cfg_load pattern=3'b110, len=3, plus simultaneous in_valid=1 -> that bit is ignored; then bits 1,1,0 -> one pulse; prior count retained.
- CNT_W=3, pattern len=1 pattern=1, stream of 9 ones -> count stops at 7 and count_sat=1 while out keeps pulsing; count_clr at a match cycle -> count=0, count_sat=0.
- Default config, bits 1,0,0 then reset=0 asynchronously mid-cycle, release, then bit 1 -> no pulse; match_count=0.
